// File: rtl/ram_word_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_word_if
//  Description : Byte-stream to word-wide synchronous RAM bridge for DFU
//                application data. Packs incoming bytes into RAM words with
//                byte enables (write path) and unpacks RAM words into an
//                outgoing byte stream (read path). Handles unaligned start
//                and end byte addresses and a RAM read latency of 1 or 2.
//  Ports       : clk_i/rstn_i        clock, async active-low reset
//                en_i                operation enable (rise start, fall end)
//                start/end_addr_i    inclusive byte address window
//                out_*               write byte stream (valid/ready)
//                in_*                read byte stream (valid/ready)
//                clear_status_i      status clear, honoured in IDLE only
//                status_o            0 OK, 7 range, 8 address, 9 not done, F end
//                ram_*               block RAM port (one strobe per word)
//  Revision    : 1.0  initial release
// ============================================================================
module ram_word_if #(
  parameter int RAM_SIZE   = 1024,
  parameter int WORD_BYTES = 4,
  parameter int RD_LATENCY = 1,
  localparam int AW  = $clog2(RAM_SIZE),
  localparam int LW  = $clog2(WORD_BYTES),
  localparam int WAW = AW - LW
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    en_i,
  input  logic [AW-1:0]           start_addr_i,
  input  logic [AW-1:0]           end_addr_i,
  input  logic [7:0]              out_data_i,
  input  logic                    out_valid_i,
  output logic                    out_ready_o,
  output logic [7:0]              in_data_o,
  output logic                    in_valid_o,
  input  logic                    in_ready_i,
  input  logic                    clear_status_i,
  output logic [3:0]              status_o,
  output logic                    ram_clke_o,
  output logic                    ram_we_o,
  output logic [WORD_BYTES-1:0]   ram_be_o,
  output logic [WAW-1:0]          ram_addr_o,
  output logic [8*WORD_BYTES-1:0] ram_wdata_o,
  input  logic [8*WORD_BYTES-1:0] ram_rdata_i
);

  // Lane index needs at least one bit even for single-byte words.
  localparam int LWS = (LW > 0) ? LW : 1;

  localparam logic [3:0]  c_ST_OK      = 4'h0;
  localparam logic [3:0]  c_ST_RANGE   = 4'h7;
  localparam logic [3:0]  c_ST_ADDRESS = 4'h8;
  localparam logic [3:0]  c_ST_NOTDONE = 4'h9;
  localparam logic [3:0]  c_ST_END     = 4'hF;
  localparam logic [AW:0] c_PTR_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [1:0]  c_WAIT_LAST  = 2'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_WR_PEND   = 3'd2,
    S_READ_REQ  = 3'd3,
    S_READ_WAIT = 3'd4,
    S_READ_OUT  = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [AW:0]             r_ptr;        // one extra bit so ptr>end is visible at the top of RAM
  logic [AW-1:0]           r_end;
  logic [3:0]              r_status, w_status_nxt;
  logic [8*WORD_BYTES-1:0] r_pack_data;
  logic [WORD_BYTES-1:0]   r_pack_be;
  logic [WAW-1:0]          r_wr_addr;    // word of the bytes in the pack buffer
  logic [8*WORD_BYTES-1:0] r_rd_word;
  logic [1:0]              r_wait_cnt;

  logic [LWS-1:0]          w_lane;
  logic [WAW-1:0]          w_ptr_word;
  logic                    w_le_end, w_at_end, w_last_lane;
  logic                    w_accept, w_rd_adv, w_capture;

  generate
    if (LW > 0) begin : g_lane_multi
      assign w_lane = r_ptr[LWS-1:0];
    end else begin : g_lane_single
      assign w_lane = '0;
    end
  endgenerate

  assign w_ptr_word  = r_ptr[AW-1:LW];
  assign w_le_end    = (r_ptr <= {1'b0, r_end});
  assign w_at_end    = (r_ptr == {1'b0, r_end});
  assign w_last_lane = (w_lane == LWS'(WORD_BYTES - 1));

  assign out_ready_o = (r_state == S_WRITE) && en_i && w_le_end;
  assign w_accept    = out_ready_o && out_valid_i;
  assign w_rd_adv    = (r_state == S_READ_OUT) && en_i && in_ready_i;
  assign w_capture   = (r_state == S_READ_WAIT) && en_i && (r_wait_cnt == c_WAIT_LAST);

  assign in_valid_o  = (r_state == S_READ_OUT);
  assign in_data_o   = in_valid_o ? r_rd_word[{w_lane, 3'b000} +: 8] : 8'h00;
  assign status_o    = r_status;
  assign ram_clke_o  = (r_state == S_WR_PEND) || (r_state == S_READ_REQ);
  assign ram_we_o    = (r_state == S_WR_PEND);
  assign ram_be_o    = ram_we_o ? r_pack_be : '0;
  assign ram_wdata_o = ram_we_o ? r_pack_data : '0;
  assign ram_addr_o  = ram_we_o ? r_wr_addr :
                       (r_state == S_READ_REQ) ? w_ptr_word : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_status_nxt = r_status;
    case (r_state)
      S_IDLE: begin
        // Clear wins over a simultaneous start; the start follows next cycle.
        if (clear_status_i) begin
          w_status_nxt = c_ST_OK;
        end else if (en_i && (r_status == c_ST_OK)) begin
          if (start_addr_i > end_addr_i) begin
            w_status_nxt = c_ST_RANGE;
            w_state_nxt  = S_DONE;
          end else if (out_valid_i) begin
            w_state_nxt  = S_WRITE;
          end else if (in_ready_i) begin
            w_state_nxt  = S_READ_REQ;
          end
        end
      end
      S_WRITE: begin
        if (w_accept) begin
          if (w_last_lane || w_at_end) w_state_nxt = S_WR_PEND;
        end else if (!en_i) begin
          if (|r_pack_be) begin
            w_state_nxt = S_WR_PEND;   // flush the partial word first
          end else begin
            w_state_nxt  = S_DONE;
            w_status_nxt = w_le_end ? c_ST_NOTDONE : c_ST_END;
          end
        end
      end
      S_WR_PEND: begin
        if (!en_i) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = w_le_end ? c_ST_NOTDONE : c_ST_END;
        end else if (!w_le_end) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = c_ST_END;
        end else begin
          w_state_nxt  = S_WRITE;
        end
      end
      S_READ_REQ: begin
        if (!en_i) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = c_ST_NOTDONE;
        end else begin
          w_state_nxt  = S_READ_WAIT;
        end
      end
      S_READ_WAIT: begin
        if (!en_i) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = c_ST_NOTDONE;
        end else if (w_capture) begin
          w_state_nxt  = S_READ_OUT;
        end
      end
      S_READ_OUT: begin
        if (!en_i) begin
          w_state_nxt  = S_DONE;
          w_status_nxt = c_ST_NOTDONE;
        end else if (w_rd_adv) begin
          if (w_at_end) begin
            w_state_nxt  = S_DONE;
            w_status_nxt = c_ST_END;
          end else if (w_last_lane) begin
            w_state_nxt  = S_READ_REQ;
          end
        end
      end
      S_DONE: begin
        if (!en_i) begin
          w_state_nxt = S_IDLE;
        end else if (out_valid_i && !w_le_end &&
                     ((r_status == c_ST_END) || (r_status == c_ST_NOTDONE))) begin
          // Host keeps pushing bytes past the window.
          w_status_nxt = c_ST_ADDRESS;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ptr       <= '0;
      r_end       <= '0;
      r_status    <= c_ST_OK;
      r_pack_data <= '0;
      r_pack_be   <= '0;
      r_wr_addr   <= '0;
      r_rd_word   <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_status <= w_status_nxt;
      if (r_state == S_IDLE) begin
        r_ptr <= {1'b0, start_addr_i};
        r_end <= end_addr_i;
      end
      if (w_accept) begin
        r_pack_data[{w_lane, 3'b000} +: 8] <= out_data_i;
        r_pack_be[w_lane]                  <= 1'b1;
        r_wr_addr                          <= w_ptr_word;
        r_ptr                              <= r_ptr + c_PTR_ONE;
      end
      if (r_state == S_WR_PEND) begin
        r_pack_data <= '0;
        r_pack_be   <= '0;
      end
      if (w_rd_adv) r_ptr <= r_ptr + c_PTR_ONE;
      if (r_state == S_READ_REQ)       r_wait_cnt <= '0;
      else if (r_state == S_READ_WAIT) r_wait_cnt <= r_wait_cnt + 2'd1;
      if (w_capture) r_rd_word <= ram_rdata_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_word_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_word_if
//  Description : Scoreboard bench for ram_word_if (WORD_BYTES=4, RD_LATENCY=2)
//                with a behavioural two-cycle block RAM model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_word_if;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en, out_valid, in_ready, clear_status;
  logic [9:0]  start_addr, end_addr;
  logic [7:0]  out_data, in_data;
  logic        out_ready, in_valid;
  logic [3:0]  status;
  logic        ram_clke, ram_we;
  logic [3:0]  ram_be;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  ram_word_if #(.RAM_SIZE(1024), .WORD_BYTES(4), .RD_LATENCY(2)) dut (
    .clk_i(clk), .rstn_i(rstn), .en_i(en),
    .start_addr_i(start_addr), .end_addr_i(end_addr),
    .out_data_i(out_data), .out_valid_i(out_valid), .out_ready_o(out_ready),
    .in_data_o(in_data), .in_valid_o(in_valid), .in_ready_i(in_ready),
    .clear_status_i(clear_status), .status_o(status),
    .ram_clke_o(ram_clke), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: two-cycle read pipeline, byte-enabled writes, bench preload port.
  logic [31:0] mem [256];
  logic [31:0] rd_p1;
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_clke && ram_we)
      for (int i = 0; i < 4; i++)
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    if (ram_clke && !ram_we) rd_p1 <= mem[ram_addr];
    ram_rdata <= rd_p1;
  end

  typedef struct {
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] rd_q[$];
  int         rd_cyc[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         n_strobes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops the expected write word / read byte whenever the DUT presents one.
  always @(negedge clk) begin
    if (rstn) begin
      if (ram_clke) n_strobes++;
      if (ram_clke && ram_we) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %0h be %0h data %0h expected none",
                   ram_addr, ram_be, ram_wdata);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("wr_addr", {24'h0, ram_addr}, {24'h0, e.addr});
          chk("wr_be", {28'h0, ram_be}, {28'h0, e.be});
          chk("wr_data", ram_wdata, e.data);
        end
      end
      if (in_valid && in_ready) begin
        rd_cyc.push_back(cyc);
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: got %0h expected none", in_data);
        end else begin
          chk("rd_byte", {24'h0, in_data}, {24'h0, rd_q.pop_front()});
        end
      end
    end
  end

  task automatic wait_status(input int limit);
    int g = 0;
    while (status == 4'h0 && g < limit) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic clear_st();
    @(posedge clk); #1;
    clear_status = 1'b1;
    @(posedge clk); #1;
    clear_status = 1'b0;
  endtask

  task automatic end_op();
    en = 1'b0; out_valid = 1'b0; in_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [9:0] s, input logic [9:0] e, input int nbytes,
                          input logic [7:0] base, input bit drop_en, input bit keep_valid);
    int sent = 0;
    int guard = 0;
    start_addr = s; end_addr = e;
    out_data = base; out_valid = 1'b1; en = 1'b1;
    while (sent < nbytes && guard < 200) begin
      @(negedge clk);
      guard++;
      if (out_ready && out_valid) begin
        @(posedge clk); #1;
        sent++;
        out_data = base + 8'(sent);
      end
    end
    if (!keep_valid) out_valid = 1'b0;
    if (drop_en) en = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] s, input logic [9:0] e);
    start_addr = s; end_addr = e;
    in_ready = 1'b1; en = 1'b1;
    wait_status(100);
  endtask

  initial begin
    int strobes_before;
    int g;
    rstn = 1'b0; en = 1'b0; out_valid = 1'b0; in_ready = 1'b0; clear_status = 1'b0;
    start_addr = '0; end_addr = '0; out_data = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    // Preload RAM words while reset is held.
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = 8'd0; pl_data = 32'hDDCCBBAA;
    @(posedge clk); #1;
    pl_addr = 8'd1; pl_data = 32'h44332211;
    @(posedge clk); #1;
    pl_en = 1'b0;

    @(negedge clk);
    chk("rst_status", {28'h0, status}, 32'h0);
    chk("rst_clke", {31'h0, ram_clke}, 32'h0);
    chk("rst_in_valid", {31'h0, in_valid}, 32'h0);
    chk("rst_out_ready", {31'h0, out_ready}, 32'h0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Unaligned read across a word boundary with a latency-2 RAM.
    rd_cyc.delete();
    rd_q.push_back(8'hCC); rd_q.push_back(8'hDD);
    rd_q.push_back(8'h11); rd_q.push_back(8'h22);
    do_read(10'd2, 10'd5);
    chk("rd_status", {28'h0, status}, 32'hF);
    chk("rd_count", rd_cyc.size(), 32'd4);
    if (rd_cyc.size() == 4) begin
      chk("rd_gap_same_word", rd_cyc[1] - rd_cyc[0], 32'd1);
      chk("rd_gap_next_word", rd_cyc[2] - rd_cyc[1], 32'd4);
      chk("rd_gap_word1", rd_cyc[3] - rd_cyc[2], 32'd1);
    end
    end_op();

    // Reset asserted during READ_WAIT aborts the read with all outputs low.
    clear_st();
    start_addr = 10'd0; end_addr = 10'd3; in_ready = 1'b1; en = 1'b1;
    g = 0;
    while (!(ram_clke && !ram_we) && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("rst_test_strobe_seen", {31'h0, ram_clke}, 32'h1);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("abort_clke", {31'h0, ram_clke}, 32'h0);
    chk("abort_in_valid", {31'h0, in_valid}, 32'h0);
    chk("abort_status", {28'h0, status}, 32'h0);
    chk("abort_in_data", {24'h0, in_data}, 32'h0);
    en = 1'b0; in_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
    @(posedge clk); #1;
    rd_q.push_back(8'hAA);
    do_read(10'd0, 10'd0);
    chk("fresh_rd_status", {28'h0, status}, 32'hF);
    end_op();

    // Aligned two-word write.
    clear_st();
    wr_q.push_back('{8'd0, 4'hF, 32'h13121110});
    wr_q.push_back('{8'd1, 4'hF, 32'h17161514});
    do_write(10'd0, 10'd7, 8, 8'h10, 1'b0, 1'b0);
    wait_status(50);
    chk("wr_aligned_status", {28'h0, status}, 32'hF);
    end_op();

    // Unaligned start and end.
    clear_st();
    wr_q.push_back('{8'd1, 4'hE, 32'h22212000});
    wr_q.push_back('{8'd2, 4'h3, 32'h00002423});
    do_write(10'd5, 10'd9, 5, 8'h20, 1'b0, 1'b0);
    wait_status(50);
    chk("wr_unaligned_status", {28'h0, status}, 32'hF);
    end_op();

    // en_i dropped mid-transfer: partial word flushed, status not-done.
    clear_st();
    wr_q.push_back('{8'd0, 4'hF, 32'h33323130});
    wr_q.push_back('{8'd1, 4'h3, 32'h00003534});
    do_write(10'd0, 10'd15, 6, 8'h30, 1'b1, 1'b0);
    wait_status(50);
    chk("wr_drop_status", {28'h0, status}, 32'h9);
    end_op();

    // Bytes still offered past the end of the window -> address error.
    clear_st();
    wr_q.push_back('{8'd8, 4'hF, 32'h43424140});
    do_write(10'h20, 10'h23, 4, 8'h40, 1'b0, 1'b1);
    wait_status(50);
    repeat (4) @(negedge clk);
    chk("wr_overrun_status", {28'h0, status}, 32'h8);
    end_op();

    // start > end: range error with no RAM access; clear ignored while enabled.
    clear_st();
    strobes_before = n_strobes;
    start_addr = 10'd8; end_addr = 10'd3; en = 1'b1;
    wait_status(20);
    chk("range_status", {28'h0, status}, 32'h7);
    clear_status = 1'b1;
    @(posedge clk); #1;
    clear_status = 1'b0;
    chk("range_clear_ignored", {28'h0, status}, 32'h7);
    chk("range_no_strobe", n_strobes - strobes_before, 32'd0);
    end_op();
    clear_st();
    chk("range_cleared", {28'h0, status}, 32'h0);

    repeat (3) @(posedge clk);
    chk("wr_q_empty", wr_q.size(), 32'd0);
    chk("rd_q_empty", rd_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
